axi_2_wb: RTL and testbench

AXI_2_WB -- requirements
Module: axi_2_wb

---
 rtl/axi_2_wb_pkg.sv | 15 +
 rtl/axi_2_wb_if.sv | 32 +++
 rtl/axi_2_wb_tmo.sv | 18 +
 rtl/axi_2_wb.sv | 108 ++++++++++
 tb/tb_axi_2_wb.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_2_wb_pkg.sv
// axi_2_wb_pkg: FSM state encoding, AXI response codes and Wishbone address prefix shared by the axi_2_wb bridge
package axi_2_wb_pkg;
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WR_COLLECT = 3'd1;
  localparam logic [2:0] WB_WR      = 3'd2;
  localparam logic [2:0] WB_RD      = 3'd3;
  localparam logic [2:0] B_RESP     = 3'd4;
  localparam logic [2:0] R_RESP     = 3'd5;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] ADR_PFX     = 8'h30;
  function automatic logic [31:0] wb_adr(input logic [11:0] a);
    return {ADR_PFX, 12'h000, a};
  endfunction
endpackage

// File: rtl/axi_2_wb_if.sv
// axi_2_wb_if: AXI-Lite slave channels and Wishbone master signals of the bridge.
// slave = bridge view, master = environment (AXI master + Wishbone slave) view.
interface axi_2_wb_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid, awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid, wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   bvalid, bready;
  logic [1:0]             bresp;
  logic                   arvalid, arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid, rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic [1:0]             rresp;
  logic                   wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]             wbm_sel_o;
  logic [31:0]            wbm_adr_o;
  logic [pDATA_WIDTH-1:0] wbm_dat_o, wbm_dat_i;
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready, wbm_ack_i, wbm_dat_i,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready, wbm_ack_i, wbm_dat_i,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/axi_2_wb_tmo.sv
// axi_2_wb_tmo: counts Wishbone cycles without ack; expired_o fires in the pTIMEOUT-th such cycle.
module axi_2_wb_tmo #(
  parameter int pTIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(pTIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d     = clear_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign expired_o = en_i && (cnt_q == W'(pTIMEOUT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/axi_2_wb.sv
// axi_2_wb: single-outstanding AXI-Lite slave to Wishbone classic master bridge, reads win ties.
// Define AXI_2_WB_TIMEOUT_EN to abort unacked Wishbone cycles after pTIMEOUT clocks with SLVERR.
module axi_2_wb
  import axi_2_wb_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 255
) (
  input  logic       wbs_clk_i,
  input  logic       wbs_rst_i,
  axi_2_wb_if.slave  bus
);
  logic [2:0]             state_q, state_d;
  logic                   aw_got_q, aw_got_d, w_got_q, w_got_d, cyc_q, cyc_d, act_q;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]             resp_q, resp_d;
  logic                   idle, coll, wb, hs_ar, hs_aw, hs_w, both, ack, tmo_exp, done;
  assign idle  = state_q == IDLE;
  assign coll  = state_q == WR_COLLECT;
  assign wb    = state_q == WB_WR || state_q == WB_RD;
  // act_q keeps every ready low until the first edge after reset release
  assign bus.arready = act_q && idle;
  assign bus.awready = act_q && (idle ? !bus.arvalid : coll && !aw_got_q);
  assign bus.wready  = act_q && (idle ? !bus.arvalid : coll && !w_got_q);
  assign hs_ar = bus.arvalid && bus.arready;
  assign hs_aw = bus.awvalid && bus.awready;
  assign hs_w  = bus.wvalid && bus.wready;
  assign both  = (aw_got_q || hs_aw) && (w_got_q || hs_w);
  assign ack   = cyc_q && bus.wbm_ack_i;
  assign done  = ack || tmo_exp;
`ifdef AXI_2_WB_TIMEOUT_EN
  axi_2_wb_tmo #(.pTIMEOUT(pTIMEOUT)) u_tmo (
    .clk       (wbs_clk_i),
    .rst       (wbs_rst_i),
    .clear_i   (!cyc_q),
    .en_i      (cyc_q && !bus.wbm_ack_i),
    .expired_o (tmo_exp)
  );
`else
  assign tmo_exp = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    resp_d   = resp_q;
    cyc_d    = cyc_q;
    if (hs_ar) begin
      addr_d  = bus.araddr;
      state_d = WB_RD;
    end
    if (hs_aw) addr_d = bus.awaddr;
    if (hs_w) wdata_d = bus.wdata;
    if (hs_aw || hs_w) begin
      aw_got_d = !both && (aw_got_q || hs_aw);
      w_got_d  = !both && (w_got_q || hs_w);
      state_d  = both ? WB_WR : WR_COLLECT;
    end
    // cyc rises one cycle after entering a bus state, so an ack is never seen in the entry cycle
    if (wb) begin
      cyc_d = !done;
      if (done) begin
        state_d = state_q == WB_WR ? B_RESP : R_RESP;
        resp_d  = ack ? RESP_OKAY : RESP_SLVERR;
        if (state_q == WB_RD) rdata_d = ack ? bus.wbm_dat_i : '0;
      end
    end
    if ((state_q == B_RESP && bus.bready) || (state_q == R_RESP && bus.rready)) state_d = IDLE;
  end
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i)
    if (wbs_rst_i) begin
      state_q  <= IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      cyc_q    <= 1'b0;
      act_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      cyc_q    <= cyc_d;
      act_q    <= 1'b1;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
    end
  assign bus.bvalid    = state_q == B_RESP;
  assign bus.bresp     = resp_q;
  assign bus.rvalid    = state_q == R_RESP;
  assign bus.rresp     = resp_q;
  assign bus.rdata     = rdata_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = state_q == WB_WR;
  assign bus.wbm_sel_o = wb ? 4'hF : 4'h0;
  assign bus.wbm_adr_o = wb ? wb_adr(addr_q[11:0]) : '0;
  assign bus.wbm_dat_o = wdata_q;
endmodule

// File: tb/tb_axi_2_wb.sv
// tb_axi_2_wb: directed plus randomized AXI-Lite traffic against a memory reference model and a Wishbone slave responder.
module tb_axi_2_wb;
  localparam int NEVER = 1_000_000;
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_txn_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stray_ack = 1'b0;
  int compared = 0, mismatched = 0, ack_wait = 0, cnt = 0;
  wb_txn_t wb_log[$];
  logic [31:0] ref_mem [4096];
  logic [31:0] wb_mem  [4096];
  always #5 clk = ~clk;
  axi_2_wb_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();
  axi_2_wb #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pTIMEOUT(8)) dut (
    .wbs_clk_i (clk),
    .wbs_rst_i (rst),
    .bus       (bus.slave)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  // Wishbone slave: acks after ack_wait stalled cycles, backed by wb_mem
  initial begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      cnt = bus.wbm_cyc_o ? cnt + 1 : 0;
      bus.wbm_ack_i = (bus.wbm_cyc_o && cnt > ack_wait) || stray_ack;
      bus.wbm_dat_i = (bus.wbm_cyc_o && !bus.wbm_we_o) ? wb_mem[bus.wbm_adr_o[11:0]] : $urandom;
      if (bus.wbm_cyc_o && bus.wbm_ack_i) begin
        wb_log.push_back('{bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o});
        if (bus.wbm_we_o) wb_mem[bus.wbm_adr_o[11:0]] = bus.wbm_dat_o;
      end
    end
  end
  task automatic wr_req(input logic [11:0] a, input logic [31:0] d, input int awd, input int wd, input int bd);
    bit aw_done, w_done, haw, hw;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    bus.awaddr = a; bus.wdata = d; bus.bready = (bd == 0);
    while (!(aw_done && w_done) && n < 40) begin
      bus.awvalid = !aw_done && n >= awd;
      bus.wvalid  = !w_done && n >= wd;
      #1;
      chk("cyc_before_wb", bus.wbm_cyc_o, 0);
      if (w_done) chk("wready_after_w", bus.wready, 0);
      if (aw_done) chk("awready_after_aw", bus.awready, 0);
      haw = bus.awvalid && bus.awready;
      hw  = bus.wvalid && bus.wready;
      step;
      aw_done |= haw; w_done |= hw; n++;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    chk("wr_accepted", {aw_done, w_done}, 2'b11);
  endtask
  task automatic wr_resp(input logic [11:0] a, input logic [31:0] d, input int w, input int bd);
    int lat, cc;
    wb_txn_t t;
    lat = 1; cc = 0;
    while (!bus.bvalid && lat < 60) begin
      chk("wr_busy_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
      cc += int'(bus.wbm_cyc_o);
      lat++;
      step;
    end
    chk("wr_latency", lat, w + 3);
    chk("wr_cyc_cycles", cc, w + 1);
    chk("bresp", {bus.bvalid, bus.bresp}, 3'b100);
    for (int i = 0; i < bd; i++) begin
      chk("b_hold", {bus.bvalid, bus.bresp, bus.awready, bus.arready}, 5'b10000);
      step;
    end
    bus.bready = 1;
    step;
    bus.bready = 0;
    #1;
    chk("bvalid_clear", bus.bvalid, 0);
    chk("wr_log_size", wb_log.size(), 1);
    if (wb_log.size() > 0) begin
      t = wb_log.pop_front();
      chk("wr_adr", t.adr, 32'h3000_0000 | a);
      chk("wr_we_sel", {t.we, t.sel}, 5'h1F);
      chk("wr_dat", t.dat, d);
    end
    ref_mem[a] = d;
  endtask
  task automatic rd_req(input logic [11:0] a, input int rd);
    bit done;
    int n;
    done = 0; n = 0;
    bus.araddr = a; bus.arvalid = 1; bus.rready = (rd == 0);
    while (!done && n < 40) begin
      #1;
      done = bus.arready;
      step;
      n++;
    end
    bus.arvalid = 0;
    chk("ar_accepted", done, 1);
  endtask
  task automatic rd_resp(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er, input int ecc, input int rd, input bit acked);
    int lat, cc;
    wb_txn_t t;
    lat = 1; cc = 0;
    while (!bus.rvalid && lat < 60) begin
      chk("rd_busy_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
      cc += int'(bus.wbm_cyc_o);
      lat++;
      step;
    end
    chk("rd_latency", lat, ecc + 2);
    chk("rd_cyc_cycles", cc, ecc);
    chk("rdata_rresp", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, er, ed});
    for (int i = 0; i < rd; i++) begin
      chk("r_hold", {bus.rvalid, bus.rresp, bus.rdata, bus.arready, bus.awready}, {1'b1, er, ed, 2'b00});
      step;
    end
    bus.rready = 1;
    step;
    bus.rready = 0;
    #1;
    chk("rvalid_clear", bus.rvalid, 0);
    chk("rd_log_size", wb_log.size(), int'(acked));
    if (acked && wb_log.size() > 0) begin
      t = wb_log.pop_front();
      chk("rd_adr", t.adr, 32'h3000_0000 | a);
      chk("rd_we_sel", {t.we, t.sel}, 5'h0F);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [11:0] a;
    logic [31:0] d;
    int w, rd, awd, wd;
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = $urandom;
      wb_mem[i]  = ref_mem[i];
    end
    #1 rst = 1;
    #1;
    chk("rst_ctrl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, 8'h00);
    chk("rst_data", {bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o}, 68'h0);
    chk("rst_rdata", {bus.rdata, bus.rresp, bus.bresp}, 36'h0);
    step;
    rst = 0;
    #1;
    chk("ready_before_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
    step;
    chk("ready_after_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);
    ack_wait = 2;
    wr_req(12'h010, 32'h0000_0005, 0, 0, 0);
    wr_resp(12'h010, 32'h0000_0005, 2, 0);
    ack_wait = 0;
    wr_req(12'h040, 32'hCAFE_0040, 2, 0, 1);
    wr_resp(12'h040, 32'hCAFE_0040, 0, 1);
    ref_mem[0] = 32'h4; wb_mem[0] = 32'h4;
    bus.araddr = 12'h000; bus.arvalid = 1; bus.rready = 1;
    bus.awaddr = 12'h123; bus.wdata = 32'h1234_5678; bus.awvalid = 1; bus.wvalid = 1;
    #1;
    chk("read_priority", {bus.arready, bus.awready, bus.wready}, 3'b100);
    step;
    bus.arvalid = 0;
    rd_resp(12'h000, 32'h4, 2'b00, 1, 0, 1);
    wr_req(12'h123, 32'h1234_5678, 0, 0, 0);
    wr_resp(12'h123, 32'h1234_5678, 0, 0);
    ack_wait = 1;
    rd_req(12'h040, 5);
    rd_resp(12'h040, ref_mem[12'h040], 2'b00, 2, 5, 1);
    stray_ack = 1;
    step;
    step;
    chk("stray_ack_ignored", {bus.arready, bus.bvalid, bus.rvalid, bus.wbm_cyc_o}, 4'b1000);
    stray_ack = 0;
    step;
    for (int k = 0; k < 30; k++) begin
      a = 12'($urandom); d = $urandom;
      w = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      awd = $urandom_range(0, 2); wd = $urandom_range(0, 2);
      ack_wait = w;
      if ($urandom_range(0, 1) == 1) begin
        wr_req(a, d, awd, wd, rd);
        wr_resp(a, d, w, rd);
      end else begin
        rd_req(a, rd);
        rd_resp(a, ref_mem[a], 2'b00, w + 1, rd, 1);
      end
    end
`ifdef AXI_2_WB_TIMEOUT_EN
    ack_wait = NEVER;
    rd_req(12'h0C4, 1);
    rd_resp(12'h0C4, 32'h0, 2'b10, 8, 1, 0);
`endif
    ack_wait = NEVER;
    rd_req(12'h0AB, 0);
    step;
    chk("cyc_before_rst", bus.wbm_cyc_o, 1);
    #1 rst = 1;
    #1;
    chk("rst_mid_ctrl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.rvalid, bus.arready}, 5'b00000);
    chk("rst_mid_bus", {bus.wbm_adr_o, bus.wbm_sel_o}, 36'h0);
    step;
    rst = 0;
    bus.rready = 0;
    step;
    ack_wait = 0;
    rd_req(12'h0AB, 0);
    rd_resp(12'h0AB, ref_mem[12'h0AB], 2'b00, 1, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
